// File: rtl/countcap_if.sv
// Wishbone slave bus bundle for countcap: a single-beat, registered-ack handshake
// with a 4-bit word address and 32-bit data.
interface countcap_if;
  logic        cyc_i;
  logic        stb_i;
  logic        we_i;
  logic [3:0]  adr_i;
  logic [31:0] dat_i;
  logic [31:0] dat_o;
  logic        ack_o;

  modport master (
    output cyc_i, stb_i, we_i, adr_i, dat_i,
    input  dat_o, ack_o
  );

  modport slave (
    input  cyc_i, stb_i, we_i, adr_i, dat_i,
    output dat_o, ack_o
  );
endinterface

// File: rtl/countcap.sv
// Multi-channel rising-edge counter and period meter behind a Wishbone slave.
// Each channel counts rising edges and captures the cycle interval between consecutive rises.
module countcap #(
  parameter int NCH = 8,
  parameter int CW  = 32
) (
  input  logic           clk_i,
  input  logic           rst_i,
  countcap_if.slave      bus,
  input  logic [NCH-1:0] countcap_i,
  output logic           irq_o
);

  localparam int SW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0] CMAX = '1;
  localparam logic [CW-1:0] CONE = CW'(1);

  localparam logic [3:0] A_ENABLE = 4'd0;
  localparam logic [3:0] A_CLEAR  = 4'd1;
  localparam logic [3:0] A_SEL    = 4'd2;
  localparam logic [3:0] A_COUNT  = 4'd3;
  localparam logic [3:0] A_PERIOD = 4'd4;
  localparam logic [3:0] A_STATUS = 4'd5;
  localparam logic [3:0] A_IRQMSK = 4'd6;

  logic [NCH-1:0] s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic [NCH-1:0] enable_q, enable_d;
  logic [NCH-1:0] mask_q, mask_d;
  logic [NCH-1:0] valid_q, valid_d;
  logic [NCH-1:0] ovf_q, ovf_d;
  logic [2:0]     sel_q, sel_d;
  logic [CW-1:0]  count_q    [NCH];
  logic [CW-1:0]  count_d    [NCH];
  logic [CW-1:0]  period_q   [NCH];
  logic [CW-1:0]  period_d   [NCH];
  logic [CW-1:0]  interval_q [NCH];
  logic [CW-1:0]  interval_d [NCH];
  logic           ack_q, ack_d;
  logic [31:0]    dat_q, dat_d;
  logic           irq_q, irq_d;

  logic           acc;
  logic           wr;
  logic [NCH-1:0] rise;
  logic [31:0]    rd_status;
  logic           sel_ok;
  logic           unused_dat;

  assign unused_dat = ^bus.dat_i[31:NCH];

  always_comb begin
    acc  = bus.cyc_i & bus.stb_i & ~ack_q;
    wr   = acc & bus.we_i;
    rise = s2_q & ~s3_q;

    ack_d    = acc;
    s1_d     = countcap_i;
    s2_d     = s1_q;
    s3_d     = s2_q;
    enable_d = enable_q;
    mask_d   = mask_q;
    sel_d    = sel_q;
    valid_d  = valid_q;
    ovf_d    = ovf_q;

    if (wr) begin
      case (bus.adr_i)
        A_ENABLE: enable_d = bus.dat_i[NCH-1:0];
        A_SEL:    sel_d    = bus.dat_i[2:0];
        A_IRQMSK: mask_d   = bus.dat_i[NCH-1:0];
        default:  ;
      endcase
    end

    // Priority per channel: counting (old ENABLE) < re-enable restart < CLEAR.
    // W1C is applied before a new overflow so a same-edge overflow keeps the flag.
    for (int n = 0; n < NCH; n++) begin
      count_d[n]    = count_q[n];
      period_d[n]   = period_q[n];
      interval_d[n] = interval_q[n];

      if (wr && bus.adr_i == A_STATUS && bus.dat_i[n])
        ovf_d[n] = 1'b0;

      if (enable_q[n]) begin
        interval_d[n] = (interval_q[n] == CMAX) ? CMAX : interval_q[n] + CONE;
        if (rise[n]) begin
          if (valid_q[n])
            period_d[n] = (interval_q[n] == CMAX) ? CMAX : interval_q[n] + CONE;
          valid_d[n]    = 1'b1;
          interval_d[n] = '0;
          if (count_q[n] == CMAX)
            ovf_d[n] = 1'b1;
          else
            count_d[n] = count_q[n] + CONE;
        end
      end

      if (wr && bus.adr_i == A_ENABLE && bus.dat_i[n] && !enable_q[n]) begin
        interval_d[n] = '0;
        valid_d[n]    = 1'b0;
      end

      if (wr && bus.adr_i == A_CLEAR && bus.dat_i[n]) begin
        count_d[n]    = '0;
        period_d[n]   = '0;
        interval_d[n] = '0;
        valid_d[n]    = 1'b0;
      end
    end

    rd_status = '0;
    for (int n = 0; n < NCH; n++) begin
      rd_status[n]     = ovf_q[n];
      rd_status[8 + n] = valid_q[n];
    end

    sel_ok = (int'(sel_q) < NCH);
    dat_d  = dat_q;
    if (acc) begin
      case (bus.adr_i)
        A_ENABLE: dat_d = 32'(enable_q);
        A_SEL:    dat_d = 32'(sel_q);
        A_COUNT:  dat_d = sel_ok ? 32'(count_q[sel_q[SW-1:0]]) : 32'd0;
        A_PERIOD: dat_d = sel_ok ? 32'(period_q[sel_q[SW-1:0]]) : 32'd0;
        A_STATUS: dat_d = rd_status;
        A_IRQMSK: dat_d = 32'(mask_q);
        default:  dat_d = 32'd0;
      endcase
    end

    irq_d = |(ovf_q & mask_q);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q     <= '0;
      s2_q     <= '0;
      s3_q     <= '0;
      enable_q <= '0;
      mask_q   <= '0;
      valid_q  <= '0;
      ovf_q    <= '0;
      sel_q    <= '0;
      ack_q    <= 1'b0;
      dat_q    <= '0;
      irq_q    <= 1'b0;
      for (int n = 0; n < NCH; n++) begin
        count_q[n]    <= '0;
        period_q[n]   <= '0;
        interval_q[n] <= '0;
      end
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      s3_q     <= s3_d;
      enable_q <= enable_d;
      mask_q   <= mask_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      sel_q    <= sel_d;
      ack_q    <= ack_d;
      dat_q    <= dat_d;
      irq_q    <= irq_d;
      for (int n = 0; n < NCH; n++) begin
        count_q[n]    <= count_d[n];
        period_q[n]   <= period_d[n];
        interval_q[n] <= interval_d[n];
      end
    end
  end

  assign bus.ack_o = ack_q;
  assign bus.dat_o = dat_q;
  assign irq_o     = irq_q;

endmodule
